// File: rtl/led_pkg.sv
// Shared encodings for the LED scanner: mode values and direction constants.
package led_pkg;

  // Run-time pattern modes, as presented on the mode input.
  typedef enum logic [1:0] {
    MODE_BOUNCE = 2'd0,
    MODE_ROTL   = 2'd1,
    MODE_ROTR   = 2'd2,
    MODE_HOLD   = 2'd3
  } mode_e;

  // Direction flag values: left moves the segment toward the MSB.
  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;

  // Direction the pattern starts in after entering a mode from home.
  function automatic logic start_dir(input mode_e m);
    return (m == MODE_ROTR) ? DIR_RIGHT : DIR_LEFT;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running prescaler producing a one-cycle update strobe whose period
// is selected at run time by speed (2^(DIV_W-speed) cycles).
module tick_prescaler #(
  parameter int DIV_W = 24
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] speed,
  output logic       strobe
);

  localparam logic [DIV_W-1:0] ALL_ONES = '1;

  logic [DIV_W-1:0] count_q;
  logic [DIV_W-1:0] count_d;
  logic [DIV_W-1:0] low_mask;

  // Next count and strobe decode; the strobe fires when the low bits
  // selected by speed are all ones, so a speed change keeps the count.
  always_comb begin
    count_d  = count_q;
    low_mask = ALL_ONES >> speed;
    strobe   = 1'b0;
    if (enable) begin
      count_d = count_q + 1'b1;
      strobe  = ((count_q & low_mask) == low_mask);
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/led_scanner.sv
// LED pattern scanner: moves a SEG_LEN-wide lit segment across WIDTH LEDs
// by bouncing, rotating or holding, advancing once per prescaler strobe.
module led_scanner
  import led_pkg::*;
#(
  parameter int WIDTH   = 18,
  parameter int SEG_LEN = 1,
  parameter int DIV_W   = 24
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [1:0]       speed,
  output logic [WIDTH-1:0] LEDR,
  output logic             dir,
  output logic             tick
);

  localparam logic [WIDTH-1:0] HOME_PATTERN =
    {{(WIDTH-SEG_LEN){1'b0}}, {SEG_LEN{1'b1}}};

  logic             strobe;
  mode_e            mode_in;
  logic [WIDTH-1:0] pattern_q, pattern_d;
  logic             dir_q, dir_d;
  mode_e            mode_q, mode_d;
  logic             tick_q, tick_d;

  assign mode_in = mode_e'(mode);

  tick_prescaler #(
    .DIV_W(DIV_W)
  ) u_prescaler (
    .CLOCK_50(CLOCK_50),
    .reset   (reset),
    .enable  (enable),
    .speed   (speed),
    .strobe  (strobe)
  );

  // Pattern update on each strobe: a mode change restarts from home
  // without shifting, otherwise the stored mode decides the step.
  always_comb begin
    pattern_d = pattern_q;
    dir_d     = dir_q;
    mode_d    = mode_q;
    tick_d    = strobe;
    if (strobe) begin
      if (mode_in != mode_q) begin
        pattern_d = HOME_PATTERN;
        dir_d     = start_dir(mode_in);
        mode_d    = mode_in;
      end else begin
        unique case (mode_q)
          MODE_BOUNCE: begin
            if (dir_q == DIR_LEFT) begin
              pattern_d = pattern_q << 1;
              if (pattern_q[WIDTH-2]) begin
                dir_d = DIR_RIGHT;
              end
            end else begin
              pattern_d = pattern_q >> 1;
              if (pattern_q[1]) begin
                dir_d = DIR_LEFT;
              end
            end
          end
          MODE_ROTL: begin
            pattern_d = {pattern_q[WIDTH-2:0], pattern_q[WIDTH-1]};
            dir_d     = DIR_LEFT;
          end
          MODE_ROTR: begin
            pattern_d = {pattern_q[0], pattern_q[WIDTH-1:1]};
            dir_d     = DIR_RIGHT;
          end
          MODE_HOLD: begin
            pattern_d = pattern_q;
          end
          default: begin
            pattern_d = pattern_q;
          end
        endcase
      end
    end
  end

  // State registers; reset returns to the home pattern moving left.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      pattern_q <= HOME_PATTERN;
      dir_q     <= DIR_LEFT;
      mode_q    <= MODE_BOUNCE;
      tick_q    <= 1'b0;
    end else begin
      pattern_q <= pattern_d;
      dir_q     <= dir_d;
      mode_q    <= mode_d;
      tick_q    <= tick_d;
    end
  end

  assign LEDR = pattern_q;
  assign dir  = dir_q;
  assign tick = tick_q;

  // The lit segment never gains or loses LEDs.
  seg_count_a : assert property (@(posedge CLOCK_50) disable iff (reset)
    $countones(pattern_q) == SEG_LEN);

endmodule

// File: tb/tb_led_scanner.sv
// Randomized self-checking bench: two scanners (SEG_LEN 1 and 2) share
// inputs and are compared each cycle against a position-based model.
module tb_led_scanner;

  localparam int W  = 6;
  localparam int DW = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic [1:0]   mode;
  logic [1:0]   speed;
  logic [W-1:0] ledr_a, ledr_b;
  logic         dir_a, dir_b;
  logic         tick_a, tick_b;

  int compare_count  = 0;
  int mismatch_count = 0;

  // Model state: prescaler count, segment position (lowest lit bit),
  // direction and stored mode per instance.
  int cnt_m;
  int pos_m  [2];
  int dir_m  [2];
  int mode_m [2];
  int tick_m;
  int seg_len [2] = '{1, 2};

  always #10 clk = ~clk;

  led_scanner #(.WIDTH(W), .SEG_LEN(1), .DIV_W(DW)) dut_a (
    .CLOCK_50(clk), .reset(reset), .enable(enable), .mode(mode),
    .speed(speed), .LEDR(ledr_a), .dir(dir_a), .tick(tick_a)
  );

  led_scanner #(.WIDTH(W), .SEG_LEN(2), .DIV_W(DW)) dut_b (
    .CLOCK_50(clk), .reset(reset), .enable(enable), .mode(mode),
    .speed(speed), .LEDR(ledr_b), .dir(dir_b), .tick(tick_b)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compare_count++;
    if (observed !== expected) begin
      mismatch_count++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time,
               observed, expected);
    end
  endtask

  function automatic logic [W-1:0] pattern_of(input int pos, input int len);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < len; i++) r[(pos + i) % W] = 1'b1;
    return r;
  endfunction

  // Advance the model by one clock edge using the inputs seen at that edge.
  task automatic modelStep(input logic rst, input logic en,
                           input int md, input int spd);
    int period;
    bit s;
    if (rst) begin
      cnt_m  = 0;
      tick_m = 0;
      for (int k = 0; k < 2; k++) begin
        pos_m[k] = 0; dir_m[k] = 1; mode_m[k] = 0;
      end
      return;
    end
    period = 1 << (DW - spd);
    s = en && ((cnt_m % period) == period - 1);
    if (en) cnt_m = (cnt_m + 1) % (1 << DW);
    tick_m = s ? 1 : 0;
    if (!s) return;
    for (int k = 0; k < 2; k++) begin
      if (md != mode_m[k]) begin
        pos_m[k]  = 0;
        dir_m[k]  = (md == 2) ? 0 : 1;
        mode_m[k] = md;
      end else begin
        case (md)
          0: begin
            if (dir_m[k] == 1) begin
              pos_m[k]++;
              if (pos_m[k] == W - seg_len[k]) dir_m[k] = 0;
            end else begin
              pos_m[k]--;
              if (pos_m[k] == 0) dir_m[k] = 1;
            end
          end
          1: begin pos_m[k] = (pos_m[k] + 1) % W;     dir_m[k] = 1; end
          2: begin pos_m[k] = (pos_m[k] + W - 1) % W; dir_m[k] = 0; end
          default: ;
        endcase
      end
    end
  endtask

  // Drive one cycle of inputs, then compare both instances after the edge.
  task automatic applyStimulus(input logic rst, input logic en,
                               input logic [1:0] md, input logic [1:0] spd);
    reset  = rst;
    enable = en;
    mode   = md;
    speed  = spd;
    @(posedge clk);
    #1;
    modelStep(rst, en, int'(md), int'(spd));
    checkOutput("ledr_seg1", 32'(ledr_a), 32'(pattern_of(pos_m[0], 1)));
    checkOutput("dir_seg1",  32'(dir_a),  32'(dir_m[0]));
    checkOutput("tick_seg1", 32'(tick_a), 32'(tick_m));
    checkOutput("ledr_seg2", 32'(ledr_b), 32'(pattern_of(pos_m[1], 2)));
    checkOutput("dir_seg2",  32'(dir_b),  32'(dir_m[1]));
    checkOutput("tick_seg2", 32'(tick_b), 32'(tick_m));
  endtask

  initial begin
    logic       cur_en;
    logic [1:0] cur_mode, cur_speed;
    reset = 1'b1; enable = 1'b0; mode = 2'd0; speed = 2'd0;
    cnt_m = 0; tick_m = 0;
    for (int k = 0; k < 2; k++) begin
      pos_m[k] = 0; dir_m[k] = 1; mode_m[k] = 0;
    end

    applyStimulus(1'b1, 1'b0, 2'd0, 2'd0);
    applyStimulus(1'b1, 1'b1, 2'd0, 2'd0);

    // Two full bounce cycles at the slowest speed.
    for (int i = 0; i < 340; i++) applyStimulus(1'b0, 1'b1, 2'd0, 2'd0);

    // Rotate-left at the fastest speed, then rotate-right.
    for (int i = 0; i < 40; i++) applyStimulus(1'b0, 1'b1, 2'd1, 2'd3);
    for (int i = 0; i < 40; i++) applyStimulus(1'b0, 1'b1, 2'd2, 2'd3);

    // Pause mid-period, and a reset that lands on a strobe edge.
    for (int i = 0; i < 5; i++)  applyStimulus(1'b0, 1'b1, 2'd0, 2'd2);
    for (int i = 0; i < 7; i++)  applyStimulus(1'b0, 1'b0, 2'd0, 2'd2);
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b1, 2'd0, 2'd2);
    while (!((cnt_m % 4) == 3)) applyStimulus(1'b0, 1'b1, 2'd0, 2'd2);
    applyStimulus(1'b1, 1'b1, 2'd0, 2'd2);
    for (int i = 0; i < 40; i++) applyStimulus(1'b0, 1'b1, 2'd0, 2'd0);

    // Randomized run: occasional mode, speed, pause and reset changes.
    cur_en = 1'b1; cur_mode = 2'd0; cur_speed = 2'd1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(39, 0) == 0) cur_mode  = 2'($urandom_range(3, 0));
      if ($urandom_range(59, 0) == 0) cur_speed = 2'($urandom_range(3, 0));
      cur_en = ($urandom_range(9, 0) != 0);
      applyStimulus(($urandom_range(299, 0) == 0), cur_en, cur_mode,
                    cur_speed);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compare_count, mismatch_count);
    $finish;
  end

endmodule
